// File: rtl/dvi_pkg.sv
// Shared DVI transmit-path types and widths.
package dvi_pkg;

  localparam int unsigned X_POS_W = 12;
  localparam int unsigned Y_POS_W = 11;

  typedef enum logic [1:0] {
    S_LOCK_WAIT,
    S_DP_RST,
    S_SYNC,
    S_ACTIVE
  } link_state_t;

endpackage

// File: rtl/dvi_link_ctrl_lock_filter.sv
// PLL lock qualifier: 2-flop synchronizer plus consecutive-lock stability counter.
module lock_filter #(
  parameter int unsigned LOCK_STABLE_CYC = 1024
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pll_lock_i,
  input  logic en_i,
  output logic lock_s_o,
  output logic lock_ok_o
);

  localparam int unsigned CNT_W = $clog2(LOCK_STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign lock_s_o  = sync2_q;
  assign lock_ok_o = sync2_q && (cnt_q == CNT_LAST);

  // Stability count: only while enabled and lock held; holds at its terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || !sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer and counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pll_lock_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/dvi_link_ctrl.sv
// DVI link bring-up sequencer: lock qualification, datapath reset, frame-aligned
// video enable, test-pattern selection and lock-loss recovery.
module dvi_link_ctrl
  import dvi_pkg::*;
#(
  parameter  int unsigned LOCK_STABLE_CYC   = 1024,
  parameter  int unsigned DP_RST_CYC        = 16,
  parameter  int unsigned PATTERN_NUM       = 4,
  parameter  int unsigned AUTO_CYCLE_FRAMES = 60,
  localparam int unsigned PATTERN_W = (PATTERN_NUM > 1) ? $clog2(PATTERN_NUM) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 pll_lock_i,
  input  logic [X_POS_W-1:0]   x_i,
  input  logic [Y_POS_W-1:0]   y_i,
  input  logic                 pattern_next_i,
  output logic                 dvi_rst_o,
  output logic                 video_en_o,
  output logic [PATTERN_W-1:0] pattern_o,
  output link_state_t          state_o,
  output logic [7:0]           lock_loss_cnt_o
);

  localparam int unsigned DP_W  = $clog2(DP_RST_CYC + 1);
  localparam int unsigned FRM_W = (AUTO_CYCLE_FRAMES > 0) ? $clog2(AUTO_CYCLE_FRAMES + 1) : 1;
  localparam logic [DP_W-1:0]      DP_LAST  = DP_W'(DP_RST_CYC - 1);
  localparam logic [FRM_W-1:0]     FRM_LAST =
    FRM_W'((AUTO_CYCLE_FRAMES == 0) ? 0 : AUTO_CYCLE_FRAMES - 1);
  localparam logic [PATTERN_W-1:0] PAT_LAST = PATTERN_W'(PATTERN_NUM - 1);

  link_state_t          state_q, state_d;
  logic [DP_W-1:0]      dp_cnt_q, dp_cnt_d;
  logic [FRM_W-1:0]     frm_q, frm_d;
  logic                 pend_q, pend_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [7:0]           loss_q, loss_d;
  logic                 dvi_rst_q, dvi_rst_d;
  logic                 ven_q, ven_d;

  logic lock_s, lock_ok;
  logic frame_start, lost, req, auto_adv;

  lock_filter #(
    .LOCK_STABLE_CYC (LOCK_STABLE_CYC)
  ) u_lock_filter (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .pll_lock_i (pll_lock_i),
    .en_i       (state_q == S_LOCK_WAIT),
    .lock_s_o   (lock_s),
    .lock_ok_o  (lock_ok)
  );

  assign frame_start = (x_i == '0) && (y_i == '0) && !dvi_rst_q;

  assign dvi_rst_o       = dvi_rst_q;
  assign video_en_o      = ven_q;
  assign pattern_o       = pat_q;
  assign state_o         = state_q;
  assign lock_loss_cnt_o = loss_q;

  // Next-state, counters and pattern; outputs are decoded from the next state so
  // they register together with it. Lock loss overrides every other event.
  always_comb begin
    state_d  = state_q;
    dp_cnt_d = dp_cnt_q;
    frm_d    = frm_q;
    pend_d   = pend_q;
    pat_d    = pat_q;
    loss_d   = loss_q;
    lost     = (state_q != S_LOCK_WAIT) && !lock_s;
    req      = pend_q || pattern_next_i;
    auto_adv = (AUTO_CYCLE_FRAMES != 0) && (frm_q == FRM_LAST);
    if (lost) begin
      state_d  = S_LOCK_WAIT;
      dp_cnt_d = '0;
      pend_d   = 1'b0;
      if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
    end else begin
      case (state_q)
        S_LOCK_WAIT: begin
          if (lock_ok) begin
            state_d  = S_DP_RST;
            dp_cnt_d = '0;
          end
        end
        S_DP_RST: begin
          if (dp_cnt_q == DP_LAST) begin
            state_d  = S_SYNC;
            dp_cnt_d = '0;
          end else begin
            dp_cnt_d = dp_cnt_q + 1'b1;
          end
        end
        S_SYNC: begin
          pend_d = 1'b0;
          if (frame_start) begin
            state_d = S_ACTIVE;
            frm_d   = '0;
          end
        end
        S_ACTIVE: begin
          pend_d = req;
          if (frame_start) begin
            if (req || auto_adv) begin
              pat_d  = (pat_q == PAT_LAST) ? '0 : pat_q + 1'b1;
              frm_d  = '0;
              pend_d = 1'b0;
            end else if (AUTO_CYCLE_FRAMES != 0) begin
              frm_d = frm_q + 1'b1;
            end
          end
        end
        default: state_d = S_LOCK_WAIT;
      endcase
    end
    dvi_rst_d = (state_d == S_LOCK_WAIT) || (state_d == S_DP_RST);
    ven_d     = (state_d == S_ACTIVE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_LOCK_WAIT;
      dp_cnt_q  <= '0;
      frm_q     <= '0;
      pend_q    <= 1'b0;
      pat_q     <= '0;
      loss_q    <= '0;
      dvi_rst_q <= 1'b1;
      ven_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dp_cnt_q  <= dp_cnt_d;
      frm_q     <= frm_d;
      pend_q    <= pend_d;
      pat_q     <= pat_d;
      loss_q    <= loss_d;
      dvi_rst_q <= dvi_rst_d;
      ven_q     <= ven_d;
    end
  end

endmodule
